// File: rtl/mp_sram_arbiter.sv
// Round-robin arbiter sharing one dual-ported SRAM between NumReq requesters.
// Grants up to two accesses per cycle and steers read data back through a ReadLat-deep pipeline.
module mp_sram_arbiter #(
   parameter int NumReq    = 4,
   parameter int DataWidth = 64,
   parameter int NumWords  = 1024,
   parameter int ReadLat   = 1,
   localparam int AddrWidth = $clog2(NumWords),
   localparam int BeWidth   = (DataWidth + 7) / 8,
   localparam int IdWidth   = (NumReq > 2) ? $clog2(NumReq) : 1
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic [NumReq-1:0]                    req_i,
   input  logic [NumReq-1:0]                    we_i,
   input  logic [NumReq-1:0][AddrWidth-1:0]     addr_i,
   input  logic [NumReq-1:0][DataWidth-1:0]     wdata_i,
   input  logic [NumReq-1:0][BeWidth-1:0]       be_i,
   output logic [NumReq-1:0]                    gnt_o,
   output logic [NumReq-1:0]                    rvalid_o,
   output logic [NumReq-1:0][DataWidth-1:0]     rdata_o,
   output logic [1:0]                           sram_req_o,
   output logic [1:0]                           sram_we_o,
   output logic [1:0][AddrWidth-1:0]            sram_addr_o,
   output logic [1:0][DataWidth-1:0]            sram_wdata_o,
   output logic [1:0][BeWidth-1:0]              sram_be_o,
   input  logic [1:0][DataWidth-1:0]            sram_rdata_i
);

   // Handshake: a requester holds req/we/addr/wdata/be until gnt_o; req_i && gnt_o in one
   // cycle is the transfer. Read data returns later as an unconditional one-cycle rvalid_o.

   logic [IdWidth-1:0]                    rr_q, rr_d, cand;
   logic [1:0]                            found;
   logic [1:0][IdWidth-1:0]               win;
   logic [1:0][ReadLat-1:0]               pv_q;
   logic [1:0][ReadLat-1:0][IdWidth-1:0]  pid_q;

   function automatic logic [IdWidth-1:0] wrap(input int v);
      return (v >= NumReq) ? IdWidth'(v - NumReq) : IdWidth'(v);
   endfunction

   // Port 1 continues the circular scan after the port-0 winner, skipping hazards.
   always_comb begin
      found = '0;
      win   = '0;
      cand  = '0;
      for (int k = 0; k < NumReq; k++) begin
         cand = wrap(int'(rr_q) + k);
         if (rst_ni && !found[0] && req_i[cand]) begin
            found[0] = 1'b1;
            win[0]   = cand;
         end
      end
      for (int k = 1; k < NumReq; k++) begin
         cand = wrap(int'(win[0]) + k);
         if (found[0] && !found[1] && req_i[cand] &&
             !((addr_i[cand] == addr_i[win[0]]) && (we_i[cand] || we_i[win[0]]))) begin
            found[1] = 1'b1;
            win[1]   = cand;
         end
      end
   end

   always_comb begin
      if (found[1])      rr_d = wrap(int'(win[1]) + 1);
      else if (found[0]) rr_d = wrap(int'(win[0]) + 1);
      else               rr_d = rr_q;
   end

   always_comb begin
      gnt_o        = '0;
      sram_req_o   = '0;
      sram_we_o    = '0;
      sram_addr_o  = '0;
      sram_wdata_o = '0;
      sram_be_o    = '0;
      for (int p = 0; p < 2; p++) begin
         if (found[p]) begin
            gnt_o[win[p]]   = 1'b1;
            sram_req_o[p]   = 1'b1;
            sram_we_o[p]    = we_i[win[p]];
            sram_addr_o[p]  = addr_i[win[p]];
            sram_wdata_o[p] = wdata_i[win[p]];
            sram_be_o[p]    = be_i[win[p]];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q  <= '0;
         pv_q  <= '0;
         pid_q <= '0;
      end else begin
         rr_q <= rr_d;
         for (int p = 0; p < 2; p++) begin
            pv_q[p][0]  <= sram_req_o[p] & ~sram_we_o[p];
            pid_q[p][0] <= win[p];
            for (int s = 1; s < ReadLat; s++) begin
               pv_q[p][s]  <= pv_q[p][s-1];
               pid_q[p][s] <= pid_q[p][s-1];
            end
         end
      end
   end

   // The two ports never carry the same requester, so their returns cannot collide.
   always_comb begin
      rvalid_o = '0;
      rdata_o  = '0;
      for (int p = 0; p < 2; p++) begin
         if (pv_q[p][ReadLat-1]) begin
            rvalid_o[pid_q[p][ReadLat-1]] = 1'b1;
            rdata_o[pid_q[p][ReadLat-1]]  = sram_rdata_i[p];
         end
      end
   end

endmodule
